// File: rtl/bcd_7seg_scan.sv
// Four-digit multiplexed 7-segment driver for packed BCD.
// Captures a packed BCD word on a strobe, scans the digits ones->thousands
// with one dark cycle at the end of every slot to suppress ghosting, blanks
// leading zeros on request and flags any non-decimal digit.
module bcd_7seg_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] packed_bcd,
    input  logic        bcd_valid,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        err
);

    localparam int              CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    logic [15:0]      cap_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       idx_reg;
    logic [3:0]       an_reg;
    logic [6:0]       seg_reg;
    logic             err_reg;

    // Per-digit views of the captured word.
    logic [3:0] digit   [4];
    logic [3:0] is_zero;
    logic [3:0] is_bad;
    logic [3:0] lz_from;   // lz_from[k]: digits k..3 are all zero

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign digit[gi]   = cap_reg[gi*4 +: 4];
            assign is_zero[gi] = (digit[gi] == 4'd0);
            assign is_bad[gi]  = (digit[gi] > 4'd9);
            assign lz_from[gi] = &is_zero[3:gi];
        end
    endgenerate

    // Common-anode, active-low segment patterns {g,f,e,d,c,b,a}; A-F show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    logic       tick;
    logic       blank_now;
    logic [3:0] cur_digit;
    logic [3:0] an_lit;

    assign tick      = (cnt_reg == CNT_MAX);
    assign cur_digit = digit[idx_reg];
    // Digit 0 is never blanked; an invalid digit is non-zero so it stops blanking.
    assign blank_now = blank_lz && (idx_reg != 2'd0) && lz_from[idx_reg];
    assign an_lit    = ~(4'b0001 << idx_reg);

    // Capture register and error flag (flag follows cap one edge later).
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_reg <= 16'h0000;
            err_reg <= 1'b0;
        end else begin
            if (bcd_valid) begin
                cap_reg <= packed_bcd;
            end
            err_reg <= |is_bad;
        end
    end

    // Slot prescaler and digit index; index steps on the tick edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            idx_reg <= 2'd0;
        end else begin
            if (tick) begin
                cnt_reg <= '0;
                idx_reg <= idx_reg + 2'd1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Registered display drive: dark on tick or blanked digit, else lit digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_reg  <= AN_OFF;
            seg_reg <= SEG_OFF;
        end else if (tick || blank_now) begin
            an_reg  <= AN_OFF;
            seg_reg <= SEG_OFF;
        end else begin
            an_reg  <= an_lit;
            seg_reg <= seg_decode(cur_digit);
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;
    assign err = err_reg;

endmodule

// File: doc/bcd_7seg_scan.md
BCD_7SEG_SCAN -- requirements
Module: bcd_7seg_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, giving clock cycles per digit slot; legal values are SCAN_DIV >= 2.
REQ-002 Port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port packed_bcd, input, 16 bits: packed BCD from the binary-to-BCD converter; [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands.
REQ-005 Port bcd_valid, input, 1 bit: capture strobe for packed_bcd.
REQ-006 Port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-007 Port an, output, 4 bits: digit enables, active-low; an[k] drives digit k.
REQ-008 Port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low (0 = lit).
REQ-009 Port err, output, 1 bit: high while any captured digit is greater than 9.

Function
REQ-010 Internal state SHALL be the capture register cap[15:0], the prescaler cnt (0..SCAN_DIV-1) and the digit index idx (0..3); an, seg and err SHALL be registered.
REQ-011 cap SHALL load packed_bcd on each edge where bcd_valid=1 and SHALL hold otherwise; packed_bcd changes without bcd_valid have no effect.
REQ-012 cnt SHALL increment every cycle and wrap from SCAN_DIV-1 to 0; the cycle with cnt=SCAN_DIV-1 is the tick.
REQ-013 idx SHALL advance by one on each tick edge, wrapping 3->0; scan order: ones, tens, hundreds, thousands.
REQ-014 Output register update, evaluated on pre-edge state: if tick, an<=4'b1111 and seg<=7'h7F (anti-ghosting dark cycle); else an<=~(1<<idx) and seg<=decode(cap digit idx).
REQ-015 Each slot SHALL therefore be lit for SCAN_DIV-1 cycles and dark for 1; a full frame is 4*SCAN_DIV cycles.
REQ-016 Decode SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex); digits A-F SHALL show dash 7'h3F.
REQ-017 With blank_lz=1, digit k (k>=1) SHALL be blanked when digits k..3 of cap are all zero; a blanked digit drives an[k]=1 and seg=7'h7F for its lit cycles.
REQ-018 Digit 0 SHALL never be blanked; interior zeros (e.g. 1005) SHALL not be blanked; an invalid digit counts as non-zero.
REQ-019 err SHALL be registered as the OR over the four cap digits of (digit>9), one edge after cap changes.
REQ-020 Latency: data captured on edge N SHALL appear on seg no earlier than edge N+1, if the current slot is lit at that edge.
REQ-021 bcd_valid coinciding with a tick SHALL be captured normally; the next slot displays the new value.
REQ-022 blank_lz SHALL be sampled combinationally into the output register each cycle; no extra latency.

Reset
REQ-023 On a rst=1 edge: cap=0, cnt=0, idx=0, an=4'b1111, seg=7'h7F, err=0; rst overrides bcd_valid.
REQ-024 Reset asserted mid-scan SHALL take effect at the next edge regardless of cnt/idx; the scan restarts from digit 0.
REQ-025 On the first edge after rst falls: an=4'b1110 and seg=7'h40 (cap=0 shows '0').

Verification (SCAN_DIV=4)
REQ-026 Reset: rst=1 for 2 cycles -> an=1111, seg=7F, err=0; after release -> an=1110, seg=40 for 3 cycles, then 1 dark cycle (1111/7F).
REQ-027 Scan: load 0x1234, blank_lz=0 -> repeating slots an 1110/19, 1101/30, 1011/24, 0111/79, each 3 lit plus 1 dark, wrap to 1110.
REQ-028 Blanking: blank_lz=1; 0x0007 -> only digit 0 lit (78), digits 1-3 an=1/seg=7F; 0x0000 -> only digit 0 lit (40); 0x1005 -> all four digits lit.
REQ-029 Invalid: load 0x9A0F -> digits 0 and 2 show 3F, digits 1 and 3 show 40 and 10, err=1; then load 0x0000 -> err=0 one edge later.
REQ-030 Capture timing: change packed_bcd with bcd_valid=0 during slot idx=2 -> display unchanged; pulse bcd_valid on a tick cycle -> the following slot shows the new digit.
REQ-031 Reset mid-scan: assert rst during slot idx=2 with cap=0x5678 -> next edge an=1111, seg=7F, err=0, cap=0; after release, digit 0 shows 40.
